sha256_uart_host: RTL and testbench
===================================

// Module: sha256_uart_host
// PURPOSE
// Host-side initiator for the UART SHA-256 hashing link: takes a message as a byte stream,
// frames it as 0x01, payload bytes, 0xFF, and transmits it over UART. Then collects the
// 32 raw digest bytes (big-endian) returned by the hashing device into a 256-bit word.
// Sits between an on-chip requester (test harness, CPU bridge) and the serial link.
// PARAMETERS
// CLK_FREQ        50_000_000  clk frequency in Hz
// BAUD            115200      UART bit rate; BAUD_DIV = CLK_FREQ/BAUD passed to UART cores
// TIMEOUT_CYCLES  5_000_000   max clk cycles between digest bytes before abort (>=16*BAUD_DIV)
// PORTS
// clk           in   1    system clock
// rst           in   1    synchronous, active-high reset
// msg_data      in   8    message byte
// msg_valid     in   1    msg_data valid
// msg_last      in   1    qualifies final message byte (sampled with msg_valid)
// msg_ready     out  1    byte accepted when msg_valid && msg_ready
// digest        out  256  assembled hash, first received byte in [255:248]
// digest_valid  out  1    one-cycle pulse: digest complete and stable
// busy          out  1    high in every state except IDLE
// err_timeout   out  1    one-cycle pulse: digest reception timed out
// err_badbyte   out  1    sticky until next frame start: payload contained 0xFF
// uart_tx       out  1    serial out, idle high
// uart_rx       in   1    serial in
// BEHAVIOUR
// Reset: msg_ready=0, digest=0, digest_valid=0, busy=0, err_*=0, uart_tx=1, state=IDLE,
//   all counters 0; reset mid-frame abandons the frame immediately (no terminator sent).
// States: IDLE, SEND_START, SEND_DATA, SEND_END, DRAIN, RECV.
// IDLE: msg_valid -> clear err_badbyte, rx_cnt=0 -> SEND_START (byte not yet accepted).
// SEND_START: launch 0x01 when TX idle -> SEND_DATA.
// TX launch rule: tx_start 1-cycle pulse; tx_pend flag set on launch and cleared once
//   tx_busy seen high; no new launch while tx_pend || tx_busy.
// SEND_DATA: msg_ready = !tx_pend && !tx_busy; on handshake launch msg_data.
//   msg_data==0xFF: byte is the terminator on the wire; set err_badbyte;
//     -> DRAIN if !msg_last, else -> RECV.
//   msg_last && msg_data!=0xFF -> SEND_END.
// SEND_END: launch 0xFF when TX idle -> RECV.
// DRAIN: msg_ready=1, bytes discarded until msg_last handshake -> RECV;
//   digest capture runs concurrently.
// Capture enable: set at terminator launch, cleared on IDLE entry. Each rx_valid shifts
//   the byte into digest from the top (digest <= {digest[247:0], rx_data}), rx_cnt++.
//   rx bytes outside capture enable are ignored.
// RECV: when rx_cnt reaches 32 and DRAIN is done -> digest_valid pulse, -> IDLE.
//   rx_cnt is 6 bits; bytes after the 32nd are ignored.
// Timeout: counter cleared at terminator launch and on each captured byte; in DRAIN or
//   RECV with rx_cnt<32, reaching TIMEOUT_CYCLES -> err_timeout pulse, no digest_valid,
//   -> IDLE.
// Simultaneous: rx_valid and timeout in the same cycle -> the byte wins and the counter
//   resets. msg_valid in the cycle digest_valid pulses is not accepted until the next cycle.
// digest holds its value after digest_valid until the first capture of the next frame.
// Latency: 1st wire bit no later than 2 cycles after msg_valid in IDLE; digest_valid
//   1 cycle after the 32nd rx_valid.
// STRUCTURE
// Instantiates existing uart_tx_core and uart_rx_core (BAUD_DIV param) for the serial PHY.
// Shared package: SOF=8'h01, EOF=8'hFF, DIGEST_BYTES=32, state encoding.
// One natural sub-module: sha256_digest_collector (capture enable, shift reg, rx_cnt,
//   timeout counter).
// TESTING (sim: CLK_FREQ=1_000_000, BAUD=100_000 -> BAUD_DIV=10; TIMEOUT_CYCLES=2000)
// "abc" (61 62 63, last on 63) -> wire 01 61 62 63 FF; bench replies ba7816bf..f20015ad
//   -> digest=256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, one pulse.
// Single byte 0x00 with last -> wire 01 00 FF; msg_ready high once; busy until digest_valid.
// msg_valid toggled randomly over 10 bytes -> every byte sent once, in order, no gaps lost.
// Responder returns only 31 bytes -> err_timeout pulse 2000 cycles after byte 31,
//   no digest_valid, busy=0.
// Payload 41 FF 42(last) -> wire 01 41 FF; 42 drained; err_badbyte=1; digest_valid after 32 bytes.
// rst asserted mid SEND_DATA -> next cycle all outputs at reset values; new frame works.

Source files
------------

// File: rtl/sha256_uart_host_pkg.sv
// Shared constants for the UART SHA-256 host link.
//   SOF / EOF      : framing bytes placed around the payload on the wire
//   DIGEST_BYTES   : number of raw digest bytes returned by the device
//   ST_*           : host FSM state encoding
package sha256_uart_host_pkg;

   localparam logic [7:0] SOF          = 8'h01;
   localparam logic [7:0] EOF          = 8'hFF;
   localparam int         DIGEST_BYTES = 32;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_SEND_START = 3'd1;
   localparam logic [2:0] ST_SEND_DATA  = 3'd2;
   localparam logic [2:0] ST_SEND_END   = 3'd3;
   localparam logic [2:0] ST_DRAIN      = 3'd4;
   localparam logic [2:0] ST_RECV       = 3'd5;

endpackage

// File: rtl/sha256_digest_collector.sv
// Collects the digest bytes returned by the hashing device.
//   frame_start : new frame begins; clears byte count and capture enable
//   cap_start   : terminator launched; enables capture, restarts timeout
//   cap_stop    : host returning to IDLE; disables capture
//   rx_valid/rx_data : bytes from the UART receiver
//   digest      : shift register, first captured byte ends up in [255:248]
//   done_next   : byte count equals DIGEST_BYTES after the coming edge
//   timeout     : no byte for TIMEOUT_CYCLES while capture is still short
module sha256_digest_collector
   import sha256_uart_host_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 5_000_000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         frame_start,
   input  logic         cap_start,
   input  logic         cap_stop,
   input  logic         rx_valid,
   input  logic [7:0]   rx_data,
   output logic [255:0] digest,
   output logic         done_next,
   output logic         timeout
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          cap_en_q, cap_en_d;
   logic [255:0]  digest_q, digest_d;
   logic [5:0]    rx_cnt_q, rx_cnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          not_full;
   logic          capture;

   always_comb begin
      not_full = (rx_cnt_q < 6'(DIGEST_BYTES));
      capture  = cap_en_q && rx_valid && not_full;
      cap_en_d = cap_en_q;
      digest_d = digest_q;
      rx_cnt_d = rx_cnt_q;
      to_cnt_d = to_cnt_q;
      if (capture) begin
         digest_d = {digest_q[247:0], rx_data};
         rx_cnt_d = rx_cnt_q + 6'd1;
         to_cnt_d = '0;
      end else if (cap_en_q && not_full) begin
         to_cnt_d = to_cnt_q + TW'(1);
      end
      if (cap_start) begin
         cap_en_d = 1'b1;
         to_cnt_d = '0;
      end
      if (cap_stop || frame_start) cap_en_d = 1'b0;
      if (frame_start) begin
         rx_cnt_d = '0;
         to_cnt_d = '0;
      end
      // A byte arriving in the expiry cycle wins over the timeout.
      timeout   = cap_en_q && not_full && !capture &&
                  (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
      done_next = (rx_cnt_d == 6'(DIGEST_BYTES));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cap_en_q <= 1'b0;
         digest_q <= '0;
         rx_cnt_q <= '0;
         to_cnt_q <= '0;
      end else begin
         cap_en_q <= cap_en_d;
         digest_q <= digest_d;
         rx_cnt_q <= rx_cnt_d;
         to_cnt_q <= to_cnt_d;
      end
   end

   assign digest = digest_q;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with two-flop input synchroniser and mid-bit sampling.
//   clk, rst   : clock, synchronous active-high reset
//   rx         : serial line, idle high
//   rx_valid   : one-cycle pulse when a byte with a good stop bit arrives
//   rx_data    : received byte, valid with rx_valid
module uart_rx_core #(
   parameter int BAUD_DIV = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       rx_valid,
   output logic [7:0] rx_data
);

   localparam int CW = $clog2(BAUD_DIV + 1);

   logic          s1_q, s2_q;
   logic          active_q, active_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;

   always_comb begin
      active_d = active_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      if (!active_q) begin
         // Falling edge of start bit: first sample lands half a bit later.
         if (!s2_q) begin
            active_d = 1'b1;
            cnt_d    = CW'(BAUD_DIV / 2 - 1);
            bit_d    = '0;
         end
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end else begin
         cnt_d = CW'(BAUD_DIV - 1);
         bit_d = bit_q + 4'd1;
         if (bit_q == 4'd0) begin
            if (s2_q) active_d = 1'b0;   // glitch, not a real start bit
         end else if (bit_q <= 4'd8) begin
            data_d = {s2_q, data_q[7:1]};
         end else begin
            active_d = 1'b0;
            valid_d  = s2_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q     <= 1'b1;
         s2_q     <= 1'b1;
         active_q <= 1'b0;
         cnt_q    <= '0;
         bit_q    <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         s1_q     <= rx;
         s2_q     <= s1_q;
         active_q <= active_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
      end
   end

   assign rx_valid = valid_q;
   assign rx_data  = data_q;

endmodule

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter.
//   clk, rst   : clock, synchronous active-high reset
//   tx_start   : one-cycle launch request, honoured only while not busy
//   tx_data    : byte to send (LSB first)
//   tx_busy    : high from the cycle after launch until the stop bit ends
//   tx         : serial line, idle high
module uart_tx_core #(
   parameter int BAUD_DIV = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_busy,
   output logic       tx
);

   localparam int CW = $clog2(BAUD_DIV + 1);

   logic          busy_q, busy_d;
   logic [9:0]    shreg_q, shreg_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [3:0]    bit_q, bit_d;

   always_comb begin
      busy_d  = busy_q;
      shreg_d = shreg_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      if (!busy_q) begin
         if (tx_start) begin
            busy_d  = 1'b1;
            shreg_d = {1'b1, tx_data, 1'b0};
            baud_d  = '0;
            bit_d   = '0;
         end
      end else if (baud_q == CW'(BAUD_DIV - 1)) begin
         baud_d  = '0;
         shreg_d = {1'b1, shreg_q[9:1]};
         if (bit_q == 4'd9) busy_d = 1'b0;
         else               bit_d  = bit_q + 4'd1;
      end else begin
         baud_d = baud_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= 1'b0;
         shreg_q <= '1;
         baud_q  <= '0;
         bit_q   <= '0;
      end else begin
         busy_q  <= busy_d;
         shreg_q <= shreg_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
      end
   end

   assign tx_busy = busy_q;
   assign tx      = busy_q ? shreg_q[0] : 1'b1;

endmodule

// File: rtl/sha256_uart_host.sv
// Host-side initiator for the UART SHA-256 link. Frames a message stream as
// SOF, payload, EOF on uart_tx, then assembles the 32 returned digest bytes.
//   clk, rst          : clock, synchronous active-high reset
//   msg_data/valid/last/ready : message byte stream (valid/ready below)
//   digest, digest_valid      : assembled hash and its one-cycle strobe
//   busy              : high whenever the FSM is not in IDLE
//   err_timeout       : one-cycle pulse, digest reception timed out
//   err_badbyte       : sticky until next frame start, payload held 0xFF
//   uart_tx, uart_rx  : serial link
// Handshake: a message byte transfers on a rising edge where msg_valid and
// msg_ready are both high; msg_data/msg_last are sampled only then, and
// msg_valid may be raised or dropped freely while msg_ready is low.
module sha256_uart_host
   import sha256_uart_host_pkg::*;
#(
   parameter int CLK_FREQ       = 50_000_000,
   parameter int BAUD           = 115200,
   parameter int TIMEOUT_CYCLES = 5_000_000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   msg_data,
   input  logic         msg_valid,
   input  logic         msg_last,
   output logic         msg_ready,
   output logic [255:0] digest,
   output logic         digest_valid,
   output logic         busy,
   output logic         err_timeout,
   output logic         err_badbyte,
   output logic         uart_tx,
   input  logic         uart_rx
);

   localparam int BAUD_DIV = CLK_FREQ / BAUD;

   logic [2:0] state_q, state_d;
   logic       tx_pend_q, tx_pend_d;
   logic       err_badbyte_q, err_badbyte_d;
   logic       err_timeout_q, err_timeout_d;
   logic       digest_valid_q, digest_valid_d;

   logic       tx_start, tx_busy, tx_idle;
   logic [7:0] tx_data;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       frame_start, cap_start, cap_stop;
   logic       done_next, timeout;

   always_comb begin
      state_d        = state_q;
      err_badbyte_d  = err_badbyte_q;
      err_timeout_d  = 1'b0;
      digest_valid_d = 1'b0;
      tx_start       = 1'b0;
      tx_data        = SOF;
      msg_ready      = 1'b0;
      frame_start    = 1'b0;
      cap_start      = 1'b0;
      // tx_busy rises one cycle after a launch; tx_pend covers that gap.
      tx_idle        = !tx_pend_q && !tx_busy;

      case (state_q)
         ST_IDLE: begin
            // The digest_valid cycle does not start a new frame.
            if (msg_valid && !digest_valid_q) begin
               err_badbyte_d = 1'b0;
               frame_start   = 1'b1;
               state_d       = ST_SEND_START;
            end
         end
         ST_SEND_START: begin
            if (tx_idle) begin
               tx_start = 1'b1;
               tx_data  = SOF;
               state_d  = ST_SEND_DATA;
            end
         end
         ST_SEND_DATA: begin
            msg_ready = tx_idle;
            if (msg_valid && tx_idle) begin
               tx_start = 1'b1;
               tx_data  = msg_data;
               if (msg_data == EOF) begin
                  // A payload 0xFF already terminates the frame on the wire.
                  err_badbyte_d = 1'b1;
                  cap_start     = 1'b1;
                  state_d       = msg_last ? ST_RECV : ST_DRAIN;
               end else if (msg_last) begin
                  state_d = ST_SEND_END;
               end
            end
         end
         ST_SEND_END: begin
            if (tx_idle) begin
               tx_start  = 1'b1;
               tx_data   = EOF;
               cap_start = 1'b1;
               state_d   = ST_RECV;
            end
         end
         ST_DRAIN: begin
            msg_ready = 1'b1;
            if (timeout) begin
               err_timeout_d = 1'b1;
               state_d       = ST_IDLE;
            end else if (msg_valid && msg_last) begin
               state_d = ST_RECV;
            end
         end
         ST_RECV: begin
            if (done_next) begin
               digest_valid_d = 1'b1;
               state_d        = ST_IDLE;
            end else if (timeout) begin
               err_timeout_d = 1'b1;
               state_d       = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      tx_pend_d = tx_start ? 1'b1 : (tx_busy ? 1'b0 : tx_pend_q);
      cap_stop  = (state_q != ST_IDLE) && (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         tx_pend_q      <= 1'b0;
         err_badbyte_q  <= 1'b0;
         err_timeout_q  <= 1'b0;
         digest_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         tx_pend_q      <= tx_pend_d;
         err_badbyte_q  <= err_badbyte_d;
         err_timeout_q  <= err_timeout_d;
         digest_valid_q <= digest_valid_d;
      end
   end

   uart_tx_core #(.BAUD_DIV(BAUD_DIV)) u_tx (
      .clk      (clk),
      .rst      (rst),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy),
      .tx       (uart_tx)
   );

   uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
      .clk      (clk),
      .rst      (rst),
      .rx       (uart_rx),
      .rx_valid (rx_valid),
      .rx_data  (rx_data)
   );

   sha256_digest_collector #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_collect (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .cap_start   (cap_start),
      .cap_stop    (cap_stop),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .digest      (digest),
      .done_next   (done_next),
      .timeout     (timeout)
   );

   assign busy         = (state_q != ST_IDLE);
   assign err_timeout  = err_timeout_q;
   assign err_badbyte  = err_badbyte_q;
   assign digest_valid = digest_valid_q;

endmodule

// File: tb/tb_sha256_uart_host.sv
// Bench for sha256_uart_host: drives message frames, decodes uart_tx into a
// byte queue, answers with digest bytes on uart_rx, and compares against a
// frame/digest model built from the link rules.
`timescale 1ns/1ps
module tb_sha256_uart_host;

   localparam int BIT_CYC = 10;   // 1 MHz / 100 kbaud
   localparam logic [255:0] ABC_DIGEST =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [7:0]   msg_data = 8'h00;
   logic         msg_valid = 1'b0;
   logic         msg_last = 1'b0;
   logic         msg_ready;
   logic [255:0] digest;
   logic         digest_valid;
   logic         busy;
   logic         err_timeout;
   logic         err_badbyte;
   logic         uart_tx;
   logic         uart_rx = 1'b1;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] wire_q[$];
   logic [7:0] pay_q[$];
   logic [7:0] rep_q[$];

   int           cyc = 0;
   int           dv_count = 0;
   int           et_count = 0;
   int           et_cycle = 0;
   int           rdy_cnt = 0;
   logic [255:0] dv_digest = '0;
   logic         dv_busy = 1'b0;

   sha256_uart_host #(
      .CLK_FREQ       (1_000_000),
      .BAUD           (100_000),
      .TIMEOUT_CYCLES (2000)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .msg_data     (msg_data),
      .msg_valid    (msg_valid),
      .msg_last     (msg_last),
      .msg_ready    (msg_ready),
      .digest       (digest),
      .digest_valid (digest_valid),
      .busy         (busy),
      .err_timeout  (err_timeout),
      .err_badbyte  (err_badbyte),
      .uart_tx      (uart_tx),
      .uart_rx      (uart_rx)
   );

   // ---------------- clock / reset block ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   // ---------------- output monitors ----------------
   always @(negedge clk) begin
      if (digest_valid === 1'b1) begin
         dv_count  = dv_count + 1;
         dv_digest = digest;
         dv_busy   = busy;
      end
      if (err_timeout === 1'b1) begin
         et_count = et_count + 1;
         et_cycle = cyc;
      end
      if (msg_ready === 1'b1) rdy_cnt = rdy_cnt + 1;
   end

   // Decode 8N1 bytes from uart_tx into wire_q.
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (uart_tx === 1'b0) begin
            repeat (BIT_CYC / 2) @(negedge clk);
            if (uart_tx === 1'b0) begin
               for (int i = 0; i < 8; i++) begin
                  repeat (BIT_CYC) @(negedge clk);
                  b[i] = uart_tx;
               end
               repeat (BIT_CYC) @(negedge clk);
               if (uart_tx === 1'b1) wire_q.push_back(b);
            end
         end
      end
   end

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Frame model: SOF, payload up to and including a first 0xFF, else EOF appended.
   function automatic bit build_frame();
      bit bad = 1'b0;
      exp_q.delete();
      exp_q.push_back(8'h01);
      foreach (pay_q[i]) begin
         exp_q.push_back(pay_q[i]);
         if (pay_q[i] == 8'hFF) begin
            bad = 1'b1;
            break;
         end
      end
      if (!bad) exp_q.push_back(8'hFF);
      return bad;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic send_byte(input logic [7:0] b, input logic last);
      int n = 0;
      msg_data  = b;
      msg_last  = last;
      msg_valid = 1'b1;
      while (msg_ready !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("msg_accept", (n < 3000), 1);
      @(negedge clk);
      msg_valid = 1'b0;
      msg_last  = 1'b0;
   endtask

   task automatic uart_send(input logic [7:0] b);
      uart_rx = 1'b0;
      repeat (BIT_CYC) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (BIT_CYC) @(negedge clk);
      end
      uart_rx = 1'b1;
      repeat (BIT_CYC) @(negedge clk);
   endtask

   task automatic run_frame(input string tag, input bit toggle);
      bit           bad;
      logic [255:0] exp_dig;
      logic [7:0]   got;
      int           dv0, et0, n, t_last;
      bad     = build_frame();
      exp_dig = '0;
      foreach (rep_q[i]) if (i < 32) exp_dig = {exp_dig[247:0], rep_q[i]};
      wire_q.delete();
      dv0 = dv_count;
      et0 = et_count;

      foreach (pay_q[i]) begin
         if (toggle) repeat ($urandom_range(0, 4)) @(negedge clk);
         send_byte(pay_q[i], (i == pay_q.size() - 1));
      end

      n = 0;
      while (wire_q.size() < exp_q.size() && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_wire_len"}, wire_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < wire_q.size()) ? wire_q[i] : 8'hxx;
         check($sformatf("%s_wire%0d", tag, i), got, exp_q[i]);
      end
      check({tag, "_busy_wait"}, busy, 1);

      foreach (rep_q[i]) uart_send(rep_q[i]);
      t_last = cyc;

      if (rep_q.size() >= 32) begin
         n = 0;
         while (dv_count == dv0 && n < 600) begin
            @(negedge clk);
            n++;
         end
         repeat (5) @(negedge clk);
         check({tag, "_dv_pulses"}, dv_count - dv0, 1);
         check({tag, "_digest"}, dv_digest, exp_dig);
         check({tag, "_busy_at_dv"}, dv_busy, 0);
         check({tag, "_digest_hold"}, digest, exp_dig);
         check({tag, "_badbyte"}, err_badbyte, bad);
         check({tag, "_no_timeout"}, et_count - et0, 0);
      end else begin
         n = 0;
         while (et_count == et0 && n < 3000) begin
            @(negedge clk);
            n++;
         end
         repeat (5) @(negedge clk);
         check({tag, "_to_pulses"}, et_count - et0, 1);
         check({tag, "_to_delay_ok"},
               ((et_cycle - t_last) >= 1985) && ((et_cycle - t_last) <= 2015), 1);
         check({tag, "_no_dv"}, dv_count - dv0, 0);
         check({tag, "_busy_after_to"}, busy, 0);
      end
   endtask

   task automatic reply_random();
      rep_q.delete();
      repeat (32) rep_q.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic reply_abc();
      rep_q.delete();
      for (int i = 0; i < 32; i++) rep_q.push_back(ABC_DIGEST[255 - 8*i -: 8]);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int rdy0;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      check("rst_msg_ready", msg_ready, 0);
      check("rst_digest", digest, 0);
      check("rst_digest_valid", digest_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_err_timeout", err_timeout, 0);
      check("rst_err_badbyte", err_badbyte, 0);
      check("rst_uart_tx", uart_tx, 1);
      repeat (20) @(negedge clk);

      // "abc"
      pay_q = '{8'h61, 8'h62, 8'h63};
      reply_abc();
      run_frame("abc", 1'b0);
      check("abc_known_digest", dv_digest, ABC_DIGEST);

      // single 0x00 byte
      pay_q = '{8'h00};
      reply_random();
      rdy0 = rdy_cnt;
      run_frame("single", 1'b0);
      check("single_ready_cycles", rdy_cnt - rdy0, 1);

      // 10 random non-0xFF bytes with msg_valid gaps
      pay_q.delete();
      repeat (10) pay_q.push_back(8'($urandom_range(0, 254)));
      reply_random();
      run_frame("toggle", 1'b1);

      // responder stops after 31 bytes
      pay_q = '{8'h5a, 8'ha5};
      reply_random();
      void'(rep_q.pop_back());
      run_frame("timeout", 1'b0);

      // payload containing the terminator value
      pay_q = '{8'h41, 8'hFF, 8'h42};
      reply_random();
      run_frame("badbyte", 1'b0);

      // reset in the middle of SEND_DATA
      send_byte(8'h10, 1'b0);
      send_byte(8'h20, 1'b0);
      check("mid_busy_before_rst", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_msg_ready", msg_ready, 0);
      check("mid_rst_digest", digest, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_err_badbyte", err_badbyte, 0);
      check("mid_rst_uart_tx", uart_tx, 1);
      check("mid_rst_digest_valid", digest_valid, 0);
      repeat (200) @(negedge clk);
      pay_q = '{8'h61, 8'h62, 8'h63};
      reply_abc();
      run_frame("after_rst", 1'b0);

      // random frames, sometimes with an embedded 0xFF
      for (int f = 0; f < 3; f++) begin
         int len;
         len = $urandom_range(1, 6);
         pay_q.delete();
         repeat (len) pay_q.push_back(8'($urandom_range(0, 254)));
         if ($urandom_range(0, 2) == 0) pay_q[$urandom_range(0, len - 1)] = 8'hFF;
         reply_random();
         run_frame($sformatf("rand%0d", f), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
